// File: rtl/usb3_stream_to_buf_in_if.sv
// Interface bundle for the USB3 stream-to-IN-buffer bridge: the source word stream
// together with the endpoint IN buffer write/commit port.
interface usb3_stream_to_buf_in_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [1:0]  s_last_bytes;

    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack;

    // Environment side: word source, IN buffer and protocol layer
    modport master (
        output s_valid, s_data, s_last, s_last_bytes,
        input  s_ready,
        input  buf_in_addr, buf_in_data, buf_in_wren,
        output buf_in_ready,
        input  buf_in_commit, buf_in_commit_len,
        output buf_in_commit_ack
    );

    // Bridge side
    modport slave (
        input  s_valid, s_data, s_last, s_last_bytes,
        output s_ready,
        output buf_in_addr, buf_in_data, buf_in_wren,
        input  buf_in_ready,
        output buf_in_commit, buf_in_commit_len,
        input  buf_in_commit_ack
    );
endinterface

// File: rtl/usb3_stream_to_buf_in.sv
// Packs a 32-bit word stream into the endpoint IN buffer, one packet at a time, and
// commits each finished packet with its byte length to the protocol layer.
module usb3_stream_to_buf_in #(
    parameter int MAX_WORDS = 256
) (
    input  logic                   clk,
    input  logic                   reset_n,
    usb3_stream_to_buf_in_if.slave bus,
    output logic [15:0]            pkt_count,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FLUSH  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [8:0] LAST_ADDR = 9'(MAX_WORDS - 1);

    logic        rstSync_q;
    state_e      state_q,   state_d;
    logic [8:0]  wordCnt_q, wordCnt_d;
    logic [8:0]  addr_q,    addr_d;
    logic [31:0] data_q,    data_d;
    logic        wren_q,    wren_d;
    logic [10:0] pendLen_q, pendLen_d;
    logic [10:0] len_q,     len_d;
    logic [15:0] pktCnt_q,  pktCnt_d;
    logic [2:0]  lastBytes;
    logic        pktEnd;

    // Reset asserts at once but releases on a clock edge, so the core leaves reset cleanly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rstSync_q <= 1'b0;
        end else begin
            rstSync_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstSync_q) begin
        if (!rstSync_q) begin
            state_q   <= IDLE;
            wordCnt_q <= 9'd0;
            addr_q    <= 9'd0;
            data_q    <= 32'd0;
            wren_q    <= 1'b0;
            pendLen_q <= 11'd0;
            len_q     <= 11'd0;
            pktCnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            wordCnt_q <= wordCnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            pendLen_q <= pendLen_d;
            len_q     <= len_d;
            pktCnt_q  <= pktCnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wordCnt_d = wordCnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        pendLen_d = pendLen_q;
        len_d     = len_q;
        pktCnt_d  = pktCnt_q;
        lastBytes = 3'd4;
        pktEnd    = 1'b0;

        // A word that ends on the MAX_WORDS limit without s_last counts as full
        if (bus.s_last && (bus.s_last_bytes != 2'd0)) begin
            lastBytes = {1'b0, bus.s_last_bytes};
        end

        unique case (state_q)
            IDLE: begin
                wordCnt_d = 9'd0;
                if (bus.buf_in_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.s_valid) begin
                    wren_d    = 1'b1;
                    addr_d    = wordCnt_q;
                    data_d    = bus.s_data;
                    wordCnt_d = wordCnt_q + 9'd1;
                    pktEnd    = bus.s_last || (wordCnt_q == LAST_ADDR);
                    if (pktEnd) begin
                        pendLen_d = {wordCnt_q, 2'b00} + {8'd0, lastBytes};
                        state_d   = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The length becomes visible together with the commit strobe
                len_d   = pendLen_q;
                state_d = COMMIT;
            end
            COMMIT: begin
                if (bus.buf_in_commit_ack) begin
                    pktCnt_d = pktCnt_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_ready           = (state_q == FILL);
    assign bus.buf_in_addr       = addr_q;
    assign bus.buf_in_data       = data_q;
    assign bus.buf_in_wren       = wren_q;
    assign bus.buf_in_commit     = (state_q == COMMIT);
    assign bus.buf_in_commit_len = len_q;
    assign pkt_count             = pktCnt_q;
    assign busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_usb3_stream_to_buf_in.sv
// Directed bench for usb3_stream_to_buf_in (MAX_WORDS=4): the driver queues expected
// buffer writes and commits, and a negedge monitor pops and compares them.
module tb_usb3_stream_to_buf_in;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pkt_count;
    logic        busy;

    usb3_stream_to_buf_in_if bus();

    usb3_stream_to_buf_in #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .pkt_count (pkt_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [10:0] len;
        logic [15:0] cnt;
        int          hold;
    } cm_t;

    wr_t wrQ[$];
    cm_t cmQ[$];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expPkt = 16'd0;
    int          expHold = 2;
    logic        ackTie = 1'b0;
    int          ackDelay = 2;
    int          ackCnt = 0;

    logic prevWren = 1'b0;
    logic prevCommit = 1'b0;
    int   holdCnt = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted
    task automatic applyStimulus(input logic [31:0] d, input logic last, input logic [1:0] lb,
                                 input logic [8:0] expAddr, input logic endsPkt,
                                 input logic [10:0] expLen);
        logic rdy;
        logic got;
        got = 1'b0;
        bus.s_data       = d;
        bus.s_last       = last;
        bus.s_last_bytes = lb;
        bus.s_valid      = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            rdy = bus.s_ready;
            if (rdy) begin
                wrQ.push_back('{expAddr, d});
                if (endsPkt) begin
                    expPkt = expPkt + 16'd1;
                    cmQ.push_back('{expLen, expPkt, expHold});
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy) got = 1'b1;
        end
        if (!got) checkOutput("accept_timeout", 32'(got), 32'd1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic waitIdle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (!busy) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) checkOutput("idle_timeout", 32'(got), 32'd1);
    endtask

    task automatic setAck(input logic tie, input int delay, input int hold);
        ackTie   = tie;
        ackDelay = delay;
        expHold  = hold;
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        checkOutput({tag, "_wren"},    32'(bus.buf_in_wren), 32'd0);
        checkOutput({tag, "_addr"},    32'(bus.buf_in_addr), 32'd0);
        checkOutput({tag, "_data"},    bus.buf_in_data, 32'd0);
        checkOutput({tag, "_commit"},  32'(bus.buf_in_commit), 32'd0);
        checkOutput({tag, "_len"},     32'(bus.buf_in_commit_len), 32'd0);
        checkOutput({tag, "_pkt"},     32'(pkt_count), 32'd0);
        checkOutput({tag, "_busy"},    32'(busy), 32'd0);
    endtask

    // Protocol-layer model: ack after ackDelay commit cycles, or tied high
    initial begin
        bus.buf_in_commit_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ackTie) begin
                bus.buf_in_commit_ack = 1'b1;
            end else if (bus.buf_in_commit) begin
                ackCnt++;
                bus.buf_in_commit_ack = (ackCnt >= ackDelay);
            end else begin
                ackCnt = 0;
                bus.buf_in_commit_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prevWren   = 1'b0;
            prevCommit = 1'b0;
            holdCnt    = 0;
        end else begin
            if (bus.buf_in_wren) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'(wrQ.size()), 32'd1);
                end else begin
                    wr_t w;
                    w = wrQ.pop_front();
                    checkOutput("wr_addr", 32'(bus.buf_in_addr), 32'(w.addr));
                    checkOutput("wr_data", bus.buf_in_data, w.data);
                end
            end
            if (bus.buf_in_commit) begin
                if (!prevCommit) begin
                    checkOutput("commit_latency", 32'(prevWren), 32'd1);
                    holdCnt = 0;
                end
                holdCnt++;
                checkOutput("commit_s_ready", 32'(bus.s_ready), 32'd0);
                if (cmQ.size() == 0) checkOutput("unexpected_commit", 32'(cmQ.size()), 32'd1);
                else checkOutput("commit_len", 32'(bus.buf_in_commit_len), 32'(cmQ[0].len));
            end else if (prevCommit && cmQ.size() != 0) begin
                cm_t c;
                c = cmQ.pop_front();
                checkOutput("commit_hold", 32'(holdCnt), 32'(c.hold));
                checkOutput("pkt_count", 32'(pkt_count), 32'(c.cnt));
            end
            prevWren   = bus.buf_in_wren;
            prevCommit = bus.buf_in_commit;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n               = 1'b1;
        bus.s_valid           = 1'b0;
        bus.s_data            = 32'd0;
        bus.s_last            = 1'b0;
        bus.s_last_bytes      = 2'd0;
        bus.buf_in_ready      = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        resetChecks("por");

        // Release: synchronizer edge first, FILL on the second edge
        reset_n          = 1'b1;
        bus.buf_in_ready = 1'b1;
        @(negedge clk);
        checkOutput("rel_edge1_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        checkOutput("rel_edge2_ready", 32'(bus.s_ready), 32'd1);

        // Three words, last carries 2 bytes: 2*4+2 = 10
        applyStimulus(32'h11111111, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'h22222222, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'h33333333, 1'b1, 2'd2, 9'd2, 1'b1, 11'd10);
        waitIdle();
        checkOutput("pkt_after_first", 32'(pkt_count), 32'd1);

        // MAX_WORDS forced end: 4 full words = 16, then the next packet restarts at 0
        applyStimulus(32'hA0A0A0A0, 1'b0, 2'd1, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hA1A1A1A1, 1'b0, 2'd1, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'hA2A2A2A2, 1'b0, 2'd1, 9'd2, 1'b0, 11'd0);
        applyStimulus(32'hA3A3A3A3, 1'b0, 2'd1, 9'd3, 1'b1, 11'd16);
        bus.buf_in_ready = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("hold_idle_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("hold_idle_busy", 32'(busy), 32'd0);
        checkOutput("pkt_after_max", 32'(pkt_count), 32'd2);
        bus.buf_in_ready = 1'b1;
        applyStimulus(32'hA4A4A4A4, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hA5A5A5A5, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'hA6A6A6A6, 1'b1, 2'd3, 9'd2, 1'b1, 11'd11);

        // s_last coinciding with the address limit, 1 byte: 3*4+1 = 13
        applyStimulus(32'hB0B0B0B0, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hB1B1B1B1, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'hB2B2B2B2, 1'b0, 2'd0, 9'd2, 1'b0, 11'd0);
        applyStimulus(32'hB3B3B3B3, 1'b1, 2'd1, 9'd3, 1'b1, 11'd13);
        waitIdle();

        // Ack delayed 10 cycles; s_last_bytes=0 means 4: 1*4+4 = 8
        setAck(1'b0, 10, 10);
        applyStimulus(32'hC0C0C0C0, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hC1C1C1C1, 1'b1, 2'd0, 9'd1, 1'b1, 11'd8);
        waitIdle();
        checkOutput("pkt_after_delay", 32'(pkt_count), 32'd5);

        // Ack tied high: single-cycle commits, single-word packet of 1 byte
        setAck(1'b1, 0, 1);
        repeat (2) @(negedge clk);
        applyStimulus(32'hD0D0D0D0, 1'b1, 2'd1, 9'd0, 1'b1, 11'd1);
        applyStimulus(32'hD1D1D1D1, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hD2D2D2D2, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'hD3D3D3D3, 1'b1, 2'd3, 9'd2, 1'b1, 11'd11);
        waitIdle();
        setAck(1'b0, 2, 2);
        repeat (2) @(negedge clk);

        // Sparse s_valid with buf_in_ready dropped mid-FILL: 2*4+3 = 11
        applyStimulus(32'hE0E0E0E0, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        @(negedge clk);
        bus.buf_in_ready = 1'b0;
        applyStimulus(32'hE1E1E1E1, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        @(negedge clk);
        applyStimulus(32'hE2E2E2E2, 1'b1, 2'd3, 9'd2, 1'b1, 11'd11);
        waitIdle();
        checkOutput("pkt_after_sparse", 32'(pkt_count), 32'd8);
        bus.buf_in_ready = 1'b1;

        // Reset after 2 of 5 words: everything clears, the partial packet is dropped
        applyStimulus(32'hF0F0F0F0, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'hF1F1F1F1, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        #2 reset_n = 1'b0;
        #1 resetChecks("mid");
        expPkt = 16'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(32'h12345678, 1'b0, 2'd0, 9'd0, 1'b0, 11'd0);
        applyStimulus(32'h9ABCDEF0, 1'b0, 2'd0, 9'd1, 1'b0, 11'd0);
        applyStimulus(32'h0F0F0F0F, 1'b1, 2'd2, 9'd2, 1'b1, 11'd10);
        waitIdle();
        checkOutput("pkt_after_reset", 32'(pkt_count), 32'd1);

        repeat (3) @(negedge clk);
        checkOutput("writes_drained", 32'(wrQ.size()), 32'd0);
        checkOutput("commits_drained", 32'(cmQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
